// File: rtl/nd_2to1_if.sv
// nd_2to1_if: req/ack message channel carrying {src, dst, dat} between network nodes.
// Latency: none (wires only).
// Backpressure: four-phase req/ack. The master holds src/dst/dat and req until ack rises,
//   then drops req. The slave drops ack once req is low.
// Modports: master drives src/dst/dat/req and samples ack; slave samples src/dst/dat/req and drives ack.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif

interface nd_2to1_if #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE
);
  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic           req;
  logic           ack;

  modport master (output src, output dst, output dat, output req, input  ack);
  modport slave  (input  src, input  dst, input  dat, input  req, output ack);
endinterface

// File: rtl/nd_2to1.sv
// nd_2to1: two-input merge node. Per-input message FIFO, round-robin arbitration onto one req/ack output.
// Latency: a message accepted at edge t into an empty block is loaded at edge t+1, so req rises after t+1.
//   Peak rate is one message per 3 cycles (IDLE / WAIT_ACK / RELEASE).
// Backpressure: an input's ack is withheld while its FIFO is full. The output holds its message until acked.
// Ports: i_clk, reset (sync, active high), ready (high once initialised),
//   snd0 (master channel out), rcv0/rcv1 (slave channels in).
// Parameters: FSZ FIFO depth (>=2), ASZ src/dst width, DSZ dat width.
// Build option: ND_2TO1_FIXED_PRIO_EN makes input 0 always win over input 1 (no round-robin pointer).
`ifndef NS_MESSAGE_FIFO_SIZE
`define NS_MESSAGE_FIFO_SIZE 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif

// nd_2to1_fifo: generic circular FIFO with a synchronous clear.
// Latency: a write is visible at rd_dat_o one cycle later. Reads are show-ahead (the tail entry is always presented).
// Backpressure: none internally. The caller must not write when full_o or read when empty_o.
// full_o/empty_o come from the registered count, so a write and a read in the same cycle leave the count unchanged.
module nd_2to1_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         i_clk,
  input  logic         clr_i,
  input  logic         wr_i,
  input  logic [W-1:0] wr_dat_i,
  input  logic         rd_i,
  output logic [W-1:0] rd_dat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  mem_q [D];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap explicitly, so D need not be a power of two.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (wr_i) head_d = wrap_inc(head_q);
    if (rd_i) tail_d = wrap_inc(tail_q);
    case ({wr_i, rd_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (clr_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not cleared. Emptiness is tracked by count alone.
  always_ff @(posedge i_clk) begin
    if (wr_i && !clr_i) mem_q[head_q] <= wr_dat_i;
  end

  assign rd_dat_o = mem_q[tail_q];
  assign full_o   = (count_q == CW'(D));
  assign empty_o  = (count_q == '0);
endmodule

module nd_2to1 #(
  parameter int FSZ = `NS_MESSAGE_FIFO_SIZE,
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE
) (
  input  logic      i_clk,
  input  logic      reset,
  output logic      ready,
  nd_2to1_if.master snd0,
  nd_2to1_if.slave  rcv0,
  nd_2to1_if.slave  rcv1
);
  typedef struct packed {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
  } msg_t;

  localparam int MW = $bits(msg_t);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_RELEASE  = 2'd2
  } state_e;

  // ready_q low marks both reset and the single init cycle that follows it.
  // All state is held at its initial value while hold is high.
  logic ready_q;
  logic hold;
  logic run;

  assign hold  = reset | ~ready_q;
  assign run   = ~hold;
  assign ready = ready_q;

  always_ff @(posedge i_clk) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= 1'b1;
  end

  // ---------------------------------------------------------------- inputs
  msg_t in0_msg, in1_msg;
  msg_t fifo0_dat, fifo1_dat;
  logic full0, full1, empty0, empty1;
  logic wr0, wr1, rd0, rd1;
  logic ack0_q, ack0_d, ack1_q, ack1_d;

  assign in0_msg = {rcv0.src, rcv0.dst, rcv0.dat};
  assign in1_msg = {rcv1.src, rcv1.dst, rcv1.dat};

  // Accept only on a fresh request: the ack of the previous message must have been released first.
  assign wr0 = run & rcv0.req & ~ack0_q & ~full0;
  assign wr1 = run & rcv1.req & ~ack1_q & ~full1;

  always_comb begin
    ack0_d = ack0_q;
    if (wr0)            ack0_d = 1'b1;
    else if (!rcv0.req) ack0_d = 1'b0;
    ack1_d = ack1_q;
    if (wr1)            ack1_d = 1'b1;
    else if (!rcv1.req) ack1_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (hold) begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
    end else begin
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
    end
  end

  assign rcv0.ack = ack0_q;
  assign rcv1.ack = ack1_q;

  nd_2to1_fifo #(.W(MW), .D(FSZ)) u_fifo0 (
    .i_clk    (i_clk),
    .clr_i    (hold),
    .wr_i     (wr0),
    .wr_dat_i (in0_msg),
    .rd_i     (rd0),
    .rd_dat_o (fifo0_dat),
    .full_o   (full0),
    .empty_o  (empty0)
  );

  nd_2to1_fifo #(.W(MW), .D(FSZ)) u_fifo1 (
    .i_clk    (i_clk),
    .clr_i    (hold),
    .wr_i     (wr1),
    .wr_dat_i (in1_msg),
    .rd_i     (rd1),
    .rd_dat_o (fifo1_dat),
    .full_o   (full1),
    .empty_o  (empty1)
  );

  // ---------------------------------------------------------------- arbiter
  logic any_vld;
  logic load;
  logic grant1;  // 1: input 1 feeds the next load, 0: input 0

  assign any_vld = ~empty0 | ~empty1;

`ifdef ND_2TO1_FIXED_PRIO_EN
  assign grant1 = empty0;
`else
  // ptr_q remembers the last granted input. On a tie the other input wins.
  // It comes out of init pointing at input 1, so input 0 wins the first tie.
  logic ptr_q, ptr_d;

  always_comb begin
    if (empty0)      grant1 = 1'b1;
    else if (empty1) grant1 = 1'b0;
    else             grant1 = ~ptr_q;
  end

  always_comb ptr_d = load ? grant1 : ptr_q;

  always_ff @(posedge i_clk) begin
    if (hold) ptr_q <= 1'b1;
    else      ptr_q <= ptr_d;
  end
`endif

  assign rd0 = load & ~grant1;
  assign rd1 = load &  grant1;

  // ---------------------------------------------------------------- output FSM
  state_e state_q, state_d;
  logic   snd0_req_w;

  always_ff @(posedge i_clk) begin
    if (hold) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (any_vld)   state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (snd0.ack)  state_d = S_RELEASE;
      S_RELEASE:  if (!snd0.ack) state_d = S_IDLE;
      default:                   state_d = S_IDLE;
    endcase
  end

  // req is a pure decode of the registered state, so it is glitch-free.
  // The FIFO pop and the output load happen on the IDLE -> WAIT_ACK edge.
  always_comb begin
    load       = 1'b0;
    snd0_req_w = 1'b0;
    case (state_q)
      S_IDLE:     load       = run & any_vld;
      S_WAIT_ACK: snd0_req_w = 1'b1;
      default:    ;
    endcase
  end

  // Output message register. It stays stable from req rise until the next load.
  msg_t out_q, out_d;

  always_comb out_d = load ? (grant1 ? fifo1_dat : fifo0_dat) : out_q;

  always_ff @(posedge i_clk) begin
    if (hold) out_q <= '0;
    else      out_q <= out_d;
  end

  assign snd0.src = out_q.src;
  assign snd0.dst = out_q.dst;
  assign snd0.dat = out_q.dat;
  assign snd0.req = snd0_req_w;
endmodule

// File: tb/tb_nd_2to1.sv
// tb_nd_2to1: checks nd_2to1 with a cycle vector table for bring-up and a single message.
// Directed sequences cover fairness, a full FIFO, simultaneous events and reset mid-transfer.
// A randomized run is scored against per-input expected queues.
module tb_nd_2to1;
  localparam int FSZ  = 4;
  localparam int ASZ  = 8;
  localparam int DSZ  = 8;
  localparam int RTOT = 40;
`ifdef ND_2TO1_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct packed {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
  } msg_t;

  typedef struct {
    logic rst;
    logic r0_req;
    logic s_ack;
    logic e_ready;
    logic e_req;
    logic e_ack0;
    logic e_ack1;
    bit   chk_msg;
  } vec_t;

  logic i_clk;
  logic rst;
  logic ready;

  nd_2to1_if #(.ASZ(ASZ), .DSZ(DSZ)) snd0_if ();
  nd_2to1_if #(.ASZ(ASZ), .DSZ(DSZ)) rcv0_if ();
  nd_2to1_if #(.ASZ(ASZ), .DSZ(DSZ)) rcv1_if ();

  nd_2to1 #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ)) dut (
    .i_clk (i_clk),
    .reset (rst),
    .ready (ready),
    .snd0  (snd0_if),
    .rcv0  (rcv0_if),
    .rcv1  (rcv1_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic msg_t mk(input int ch, input int k);
    msg_t m;
    m.src = ASZ'(16 * ch + k + 1);
    m.dst = ASZ'(8'hC0 + k);
    m.dat = DSZ'(128 * ch + k);
    return m;
  endfunction

  function automatic logic get_ack(input int ch);
    return (ch == 0) ? rcv0_if.ack : rcv1_if.ack;
  endfunction

  function automatic logic get_req_in(input int ch);
    return (ch == 0) ? rcv0_if.req : rcv1_if.req;
  endfunction

  function automatic msg_t get_out();
    return {snd0_if.src, snd0_if.dst, snd0_if.dat};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input int ch, input msg_t m, input logic r);
    if (ch == 0) begin
      rcv0_if.src = m.src; rcv0_if.dst = m.dst; rcv0_if.dat = m.dat; rcv0_if.req = r;
    end else begin
      rcv1_if.src = m.src; rcv1_if.dst = m.dst; rcv1_if.dat = m.dat; rcv1_if.req = r;
    end
  endtask

  task automatic wait_ack(input int ch, input logic val, input int lim, output bit ok);
    int n;
    n = 0;
    while (get_ack(ch) !== val && n < lim) begin
      step();
      n++;
    end
    ok = (get_ack(ch) === val);
  endtask

  // On success, completes the four-phase handshake. On timeout, leaves req high.
  task automatic try_push(input int ch, input msg_t m, input int lim, output bit ok);
    bit ok2;
    drive(ch, m, 1'b1);
    wait_ack(ch, 1'b1, lim, ok);
    if (ok) begin
      drive(ch, m, 1'b0);
      wait_ack(ch, 1'b0, lim, ok2);
    end
  endtask

  task automatic push(input int ch, input msg_t m);
    bit ok;
    try_push(ch, m, 50, ok);
    chk("push_ack", ok, 1);
    if (!ok) drive(ch, m, 1'b0);
  endtask

  task automatic recv(input string nm, input msg_t e);
    int n;
    n = 0;
    while (snd0_if.req !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk({nm, "_req"}, snd0_if.req, 1);
    chk(nm, get_out(), e);
    snd0_if.ack = 1'b1;
    step();
    chk({nm, "_drop"}, snd0_if.req, 0);
    snd0_if.ack = 1'b0;
    step();
  endtask

  initial begin : main
    vec_t vt[8];
    msg_t m1, got, ex, xm, a0, a1, b1;
    msg_t q0[$];
    msg_t q1[$];
    msg_t cur[2];
    int   sent[2];
    bit   pa[2];
    bit   pr, ok, ok2;
    int   nack, cnt, n_recv, ch, idx;

    rst = 1'b1;
    snd0_if.ack = 1'b0;
    drive(0, '0, 1'b0);
    drive(1, '0, 1'b0);
    m1 = {8'h01, 8'h05, 8'hA5};

    // ---- bring-up and single message, one row per clock edge
    //          rst   r0req s_ack  ready  req   ack0  ack1  msg
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      rst = vt[i].rst;
      snd0_if.ack = vt[i].s_ack;
      drive(0, m1, vt[i].r0_req);
      step();
      chk($sformatf("vec%0d_ready", i), ready, vt[i].e_ready);
      chk($sformatf("vec%0d_req", i), snd0_if.req, vt[i].e_req);
      chk($sformatf("vec%0d_ack0", i), rcv0_if.ack, vt[i].e_ack0);
      chk($sformatf("vec%0d_ack1", i), rcv1_if.ack, vt[i].e_ack1);
      if (vt[i].chk_msg) chk($sformatf("vec%0d_msg", i), get_out(), m1);
    end

    // ---- fairness: 3 messages per input, consumer stalled during preload
    for (int k = 0; k < 3; k++) push(0, mk(0, k));
    for (int k = 0; k < 3; k++) push(1, mk(1, k));
    for (int k = 0; k < 6; k++) begin
      ch  = FIXED ? k / 3 : k % 2;
      idx = FIXED ? k % 3 : k / 2;
      recv($sformatf("fair%0d", k), mk(ch, idx));
    end

    // ---- full FIFO on input 1 with the consumer stalled
    nack = 0;
    for (int k = 0; k < FSZ + 2; k++) begin
      try_push(1, mk(1, 10 + k), 20, ok);
      if (ok) nack++;
    end
    chk("full_ack_count", nack, FSZ + 1);
    chk("full_last_unacked", rcv1_if.ack, 0);
    fork
      begin
        wait_ack(1, 1'b1, 200, ok2);
        chk("full_late_ack", ok2, 1);
        drive(1, mk(1, 10 + FSZ + 1), 1'b0);
        wait_ack(1, 1'b0, 20, ok2);
      end
      begin
        for (int k = 0; k < FSZ + 2; k++) recv($sformatf("full_msg%0d", k), mk(1, 10 + k));
      end
    join

    // ---- simultaneous: both inputs write on the edge that loads from FIFO 0
    xm = mk(1, 30); a0 = mk(0, 31); a1 = mk(0, 32); b1 = mk(1, 33);
    push(1, xm);
    push(0, a0);
    chk("sim_x", get_out(), xm);
    snd0_if.ack = 1'b1;
    step();
    snd0_if.ack = 1'b0;
    step();
    drive(0, a1, 1'b1);
    drive(1, b1, 1'b1);
    step();
    chk("sim_ack0", rcv0_if.ack, 1);
    chk("sim_ack1", rcv1_if.ack, 1);
    chk("sim_req", snd0_if.req, 1);
    drive(0, a1, 1'b0);
    drive(1, b1, 1'b0);
    recv("sim_a0", a0);
    recv("sim_2nd", FIXED ? a1 : b1);
    recv("sim_3rd", FIXED ? b1 : a1);

    // ---- reset while a transfer is pending and two messages are buffered
    for (int k = 0; k < 3; k++) push(0, mk(0, 40 + k));
    chk("rst_pre_req", snd0_if.req, 1);
    rst = 1'b1;
    step();
    chk("rst_req", snd0_if.req, 0);
    chk("rst_ack0", rcv0_if.ack, 0);
    chk("rst_ack1", rcv1_if.ack, 0);
    chk("rst_ready", ready, 0);
    rst = 1'b0;
    step();
    chk("rst_reinit_ready", ready, 1);
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (snd0_if.req) cnt++;
      step();
    end
    chk("rst_no_stale", cnt, 0);
    push(0, mk(0, 50));
    recv("rst_fresh", mk(0, 50));

    // ---- randomized traffic against per-input expected queues
    sent[0] = 0; sent[1] = 0; n_recv = 0;
    pa[0] = get_ack(0); pa[1] = get_ack(1); pr = snd0_if.req;
    for (int cyc = 0; cyc < 4000 && n_recv < 2 * RTOT; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (get_ack(c) && !pa[c]) begin
          if (c == 0) q0.push_back(cur[c]);
          else        q1.push_back(cur[c]);
          drive(c, cur[c], 1'b0);
        end else if (!get_ack(c) && !get_req_in(c) && sent[c] < RTOT && $urandom_range(0, 2) == 0) begin
          cur[c].src = ASZ'($urandom);
          cur[c].dst = ASZ'($urandom);
          cur[c].dat = DSZ'(128 * c + sent[c]);
          sent[c]++;
          drive(c, cur[c], 1'b1);
        end
        pa[c] = get_ack(c);
      end
      if (snd0_if.req && !pr) begin
        got = get_out();
        if (!got.dat[DSZ-1] && q0.size() > 0)     ex = q0.pop_front();
        else if (got.dat[DSZ-1] && q1.size() > 0) ex = q1.pop_front();
        else                                      ex = ~got;
        chk("rand_msg", got, ex);
        n_recv++;
      end
      pr = snd0_if.req;
      if (snd0_if.req && !snd0_if.ack && $urandom_range(0, 1) == 1) snd0_if.ack = 1'b1;
      else if (!snd0_if.req && snd0_if.ack)                          snd0_if.ack = 1'b0;
      step();
    end
    chk("rand_recv_count", n_recv, 2 * RTOT);
    chk("rand_left_in_model", q0.size() + q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
